// File: rtl/dmi_dm_responder_if.sv
// ---------------------------------------------------------------------------
// dmi_dm_responder_if
// Bus bundle between the debug module responder and its surroundings.
//   DMI side : io_reg_en / io_reg_wr_en / io_reg_wr_addr / io_reg_wr_data in,
//              io_rd_data out (registered read data).
//   Core side: io_acc_valid / io_acc_write / io_acc_regno / io_acc_wdata out,
//              io_acc_ready, io_acc_resp_valid / io_acc_resp_err /
//              io_acc_resp_data in.
// Modports:
//   slave  - the debug module (dmi_dm_responder).
//   master - the environment: DMI driver plus the core's register access port.
// ---------------------------------------------------------------------------
interface dmi_dm_responder_if;
    logic        io_reg_en;
    logic        io_reg_wr_en;
    logic [6:0]  io_reg_wr_addr;
    logic [31:0] io_reg_wr_data;
    logic [31:0] io_rd_data;

    logic        io_acc_valid;
    logic        io_acc_ready;
    logic        io_acc_write;
    logic [15:0] io_acc_regno;
    logic [31:0] io_acc_wdata;
    logic        io_acc_resp_valid;
    logic        io_acc_resp_err;
    logic [31:0] io_acc_resp_data;

    modport slave (
        input  io_reg_en, io_reg_wr_en, io_reg_wr_addr, io_reg_wr_data,
        output io_rd_data,
        output io_acc_valid, io_acc_write, io_acc_regno, io_acc_wdata,
        input  io_acc_ready, io_acc_resp_valid, io_acc_resp_err, io_acc_resp_data
    );

    modport master (
        output io_reg_en, io_reg_wr_en, io_reg_wr_addr, io_reg_wr_data,
        input  io_rd_data,
        input  io_acc_valid, io_acc_write, io_acc_regno, io_acc_wdata,
        output io_acc_ready, io_acc_resp_valid, io_acc_resp_err, io_acc_resp_data
    );
endinterface

// File: rtl/dmi_dm_responder.sv
// ---------------------------------------------------------------------------
// dmi_dm_responder
// Minimal RISC-V debug module sitting at the end of the DMI bus. Decodes DMI
// reads/writes to data0, dmcontrol, dmstatus, abstractcs and command, and runs
// an abstract access-register FSM that performs one GPR/CSR access on the core
// through a valid/ready request and a response strobe.
// Ports:
//   io_core_clk        clock
//   io_core_rst_n      synchronous active-low reset
//   bus                dmi_dm_responder_if.slave (DMI bus + core access port)
//   io_dmi_hard_reset  clears all DM state, same effect as dmactive=0
//   io_core_halted     core halted status
//   io_haltreq         dmcontrol.haltreq gated by dmactive
//   io_resumereq       single-cycle resume request pulse
//   io_ndmreset        dmcontrol.ndmreset gated by dmactive
// ---------------------------------------------------------------------------
module dmi_dm_responder #(
    parameter int TIMEOUT = 256,
    parameter int VERSION = 2
) (
    input  logic              io_core_clk,
    input  logic              io_core_rst_n,
    dmi_dm_responder_if.slave bus,
    input  logic              io_dmi_hard_reset,
    input  logic              io_core_halted,
    output logic              io_haltreq,
    output logic              io_resumereq,
    output logic              io_ndmreset
);
    localparam logic [6:0] A_DATA0      = 7'h04;
    localparam logic [6:0] A_DMCONTROL  = 7'h10;
    localparam logic [6:0] A_DMSTATUS   = 7'h11;
    localparam logic [6:0] A_ABSTRACTCS = 7'h16;
    localparam logic [6:0] A_COMMAND    = 7'h17;
    localparam int             CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [3:0]     VER4     = 4'(VERSION);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_dmactive;
    logic          r_haltreq;
    logic          r_ndmreset;
    logic          r_resumereq;
    logic [31:0]   r_data0;
    logic [2:0]    r_cmderr;
    logic          r_acc_write;
    logic [15:0]   r_acc_regno;
    logic [31:0]   r_acc_wdata;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rd_data;

    logic          w_wr;
    logic          w_rd;
    logic          w_ctl_wr;
    logic          w_data0_acc;
    logic          w_acs_wr;
    logic          w_cmd_wr;
    logic          w_cmd_bad;
    logic          w_cmd_start;
    logic          w_busy;
    logic          w_resp;
    logic          w_timeout;
    logic          w_active_nxt;
    logic          w_clear;
    logic [2:0]    w_cmderr_nxt;
    logic [31:0]   w_rd_mux;

    // ---------------- access decode ----------------
    assign w_wr        = bus.io_reg_en &  bus.io_reg_wr_en;
    assign w_rd        = bus.io_reg_en & ~bus.io_reg_wr_en;
    assign w_ctl_wr    = w_wr & (bus.io_reg_wr_addr == A_DMCONTROL);
    assign w_data0_acc = bus.io_reg_en & (bus.io_reg_wr_addr == A_DATA0);
    assign w_acs_wr    = w_wr & (bus.io_reg_wr_addr == A_ABSTRACTCS);
    assign w_cmd_wr    = w_wr & (bus.io_reg_wr_addr == A_COMMAND) & r_dmactive;
    assign w_cmd_bad   = (bus.io_reg_wr_data[31:24] != 8'd0) ||
                         (bus.io_reg_wr_data[22:20] != 3'd2);
    assign w_cmd_start = w_cmd_wr & ~w_busy & (r_cmderr == 3'd0) & ~w_cmd_bad &
                         io_core_halted & bus.io_reg_wr_data[17];

    assign w_resp    = (r_state == ST_WAIT) & bus.io_acc_resp_valid;
    // A response in the last counted cycle still wins over the timeout.
    assign w_timeout = (r_state == ST_WAIT) & ~bus.io_acc_resp_valid & (r_cnt == CNT_LAST);

    // dmactive=0 (written or forced by hard reset) holds every other DM register at zero.
    assign w_active_nxt = ~io_dmi_hard_reset & (w_ctl_wr ? bus.io_reg_wr_data[0] : r_dmactive);
    assign w_clear      = ~w_active_nxt;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge io_core_clk) begin
        if (!io_core_rst_n) r_state <= ST_IDLE;
        else                r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_cmd_start)                 w_state_nxt = ST_REQ;
            ST_REQ:  if (bus.io_acc_ready)            w_state_nxt = ST_WAIT;
            ST_WAIT: if (w_resp || w_timeout)         w_state_nxt = ST_IDLE;
            default:                                  w_state_nxt = ST_IDLE;
        endcase
        if (w_clear) w_state_nxt = ST_IDLE;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_busy           = (r_state != ST_IDLE);
        bus.io_acc_valid = (r_state == ST_REQ);
    end

    // ---------------- cmderr next value ----------------
    always_comb begin
        w_cmderr_nxt = r_cmderr;
        if (w_busy) begin
            if ((w_data0_acc || w_cmd_wr) && r_cmderr == 3'd0) w_cmderr_nxt = 3'd1;
        end else begin
            if (w_acs_wr) w_cmderr_nxt = r_cmderr & ~bus.io_reg_wr_data[10:8];
            if (w_cmd_wr && r_cmderr == 3'd0) begin
                if (w_cmd_bad)            w_cmderr_nxt = 3'd2;
                else if (!io_core_halted) w_cmderr_nxt = 3'd4;
            end
        end
        if ((w_resp && bus.io_acc_resp_err) || w_timeout) w_cmderr_nxt = 3'd3;
    end

    // ---------------- read mux ----------------
    always_comb begin
        w_rd_mux = 32'd0;
        case (bus.io_reg_wr_addr)
            A_DATA0:      w_rd_mux = r_data0;
            A_DMCONTROL:  w_rd_mux = {r_haltreq, 29'd0, r_ndmreset, r_dmactive};
            A_DMSTATUS:   w_rd_mux = {20'd0, ~io_core_halted, ~io_core_halted,
                                      io_core_halted, io_core_halted, 1'b1, 3'd0, VER4};
            A_ABSTRACTCS: w_rd_mux = {19'd0, w_busy, 1'b0, r_cmderr, 4'd0, 4'd1};
            default:      w_rd_mux = 32'd0;
        endcase
    end

    // ---------------- DM registers ----------------
    always_ff @(posedge io_core_clk) begin
        if (!io_core_rst_n) begin
            r_rd_data   <= 32'd0;
            r_dmactive  <= 1'b0;
            r_haltreq   <= 1'b0;
            r_ndmreset  <= 1'b0;
            r_resumereq <= 1'b0;
            r_data0     <= 32'd0;
            r_cmderr    <= 3'd0;
            r_acc_write <= 1'b0;
            r_acc_regno <= 16'd0;
            r_acc_wdata <= 32'd0;
            r_cnt       <= '0;
        end else begin
            if (w_rd) r_rd_data <= w_rd_mux;
            r_resumereq <= 1'b0;
            if (w_clear) begin
                r_dmactive  <= 1'b0;
                r_haltreq   <= 1'b0;
                r_ndmreset  <= 1'b0;
                r_data0     <= 32'd0;
                r_cmderr    <= 3'd0;
                r_acc_write <= 1'b0;
                r_acc_regno <= 16'd0;
                r_acc_wdata <= 32'd0;
                r_cnt       <= '0;
            end else begin
                r_dmactive <= 1'b1;
                if (w_ctl_wr) begin
                    r_haltreq   <= bus.io_reg_wr_data[31];
                    r_ndmreset  <= bus.io_reg_wr_data[1];
                    r_resumereq <= bus.io_reg_wr_data[30] & ~bus.io_reg_wr_data[31];
                end
                if (w_wr && bus.io_reg_wr_addr == A_DATA0 && !w_busy)
                    r_data0 <= bus.io_reg_wr_data;
                // Read response data overrides any data0 write in the same cycle.
                if (w_resp && !bus.io_acc_resp_err && !r_acc_write)
                    r_data0 <= bus.io_acc_resp_data;
                r_cmderr <= w_cmderr_nxt;
                if (r_state == ST_WAIT) r_cnt <= r_cnt + 1'b1;
                else                    r_cnt <= '0;
                if (w_cmd_start) begin
                    r_acc_write <= bus.io_reg_wr_data[16];
                    r_acc_regno <= bus.io_reg_wr_data[15:0];
                    r_acc_wdata <= r_data0;
                end
            end
        end
    end

    assign bus.io_rd_data   = r_rd_data;
    assign bus.io_acc_write = r_acc_write;
    assign bus.io_acc_regno = r_acc_regno;
    assign bus.io_acc_wdata = r_acc_wdata;
    assign io_haltreq       = r_haltreq  & r_dmactive;
    assign io_ndmreset      = r_ndmreset & r_dmactive;
    assign io_resumereq     = r_resumereq;
endmodule

// File: tb/tb_dmi_dm_responder.sv
module tb_dmi_dm_responder;
    localparam int TIMEOUT = 256;
    localparam int VERSION = 2;

    logic clk;
    logic rst_n;
    logic hard_rst;
    logic halted;
    logic haltreq;
    logic resumereq;
    logic ndmreset;

    dmi_dm_responder_if bus_if ();

    dmi_dm_responder #(.TIMEOUT(TIMEOUT), .VERSION(VERSION)) dut (
        .io_core_clk       (clk),
        .io_core_rst_n     (rst_n),
        .bus               (bus_if),
        .io_dmi_hard_reset (hard_rst),
        .io_core_halted    (halted),
        .io_haltreq        (haltreq),
        .io_resumereq      (resumereq),
        .io_ndmreset       (ndmreset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [6:0] addr; logic [31:0] data; } rd_exp_t;
    typedef struct { logic w; logic [15:0] regno; logic [31:0] wdata; } acc_t;
    rd_exp_t rd_q[$];
    acc_t    acc_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int resume_cnt = 0;

    // Behavioural model of the debug module at transaction level.
    logic [31:0] m_data0;
    logic [2:0]  m_cmderr;
    logic        m_dmactive, m_haltreq, m_ndmreset, m_busy;
    int          m_resume_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_data0 = 0; m_cmderr = 0; m_dmactive = 0; m_haltreq = 0; m_ndmreset = 0; m_busy = 0;
    endtask

    task automatic model_read(input logic [6:0] a, output logic [31:0] v);
        case (a)
            7'h04: begin
                v = m_data0;
                if (m_busy && m_cmderr == 3'd0) m_cmderr = 3'd1;
            end
            7'h10:   v = {m_haltreq, 29'd0, m_ndmreset, m_dmactive};
            7'h11:   v = 32'(VERSION) + 32'h80 + (halted ? 32'h300 : 32'hC00);
            7'h16:   v = 32'd1 + (32'(m_cmderr) << 8) + (m_busy ? 32'h1000 : 32'h0);
            default: v = 32'd0;
        endcase
    endtask

    task automatic model_write(input logic [6:0] a, input logic [31:0] d);
        if (a == 7'h10) begin
            if (!d[0]) model_clear();
            else begin
                m_dmactive = 1; m_haltreq = d[31]; m_ndmreset = d[1];
                if (d[30] && !d[31]) m_resume_exp++;
            end
        end else if (m_dmactive) begin
            if (a == 7'h04) begin
                if (m_busy) begin
                    if (m_cmderr == 3'd0) m_cmderr = 3'd1;
                end else m_data0 = d;
            end else if (a == 7'h16) begin
                if (!m_busy) m_cmderr = m_cmderr & ~d[10:8];
            end
        end
    endtask

    task automatic model_cmd(input logic [31:0] c, output bit start);
        start = 0;
        if (m_dmactive) begin
            if (m_busy) begin
                if (m_cmderr == 3'd0) m_cmderr = 3'd1;
            end else if (m_cmderr != 3'd0) begin
                start = 0;
            end else if (c[31:24] != 8'd0 || c[22:20] != 3'd2) m_cmderr = 3'd2;
            else if (!halted) m_cmderr = 3'd4;
            else if (c[17]) start = 1;
        end
    endtask

    task automatic bus_access(input logic wr, input logic [6:0] a, input logic [31:0] d);
        bus_if.io_reg_en = 1; bus_if.io_reg_wr_en = wr;
        bus_if.io_reg_wr_addr = a; bus_if.io_reg_wr_data = d;
        tick();
        bus_if.io_reg_en = 0; bus_if.io_reg_wr_en = 0;
    endtask

    task automatic dmi_write(input logic [6:0] a, input logic [31:0] d);
        model_write(a, d);
        bus_access(1'b1, a, d);
    endtask

    task automatic dmi_read(input logic [6:0] a);
        rd_exp_t e;
        logic [31:0] v;
        model_read(a, v);
        e.addr = a; e.data = v;
        rd_q.push_back(e);
        bus_access(1'b0, a, 32'd0);
    endtask

    task automatic resp_pulse(input bit err, input logic [31:0] d);
        bus_if.io_acc_resp_valid = 1; bus_if.io_acc_resp_err = err; bus_if.io_acc_resp_data = d;
        tick();
        bus_if.io_acc_resp_valid = 0; bus_if.io_acc_resp_err = 0;
    endtask

    // Issue a command; when accepted: handshake, then respond after resp_dly cycles.
    task automatic run_cmd(input logic [31:0] c, input int rdy_dly, input int resp_dly,
                           input bit err, input logic [31:0] rdata);
        bit   start;
        acc_t e;
        model_cmd(c, start);
        if (start) begin
            e.w = c[16]; e.regno = c[15:0]; e.wdata = m_data0;
            acc_q.push_back(e);
        end
        bus_access(1'b1, 7'h17, c);
        if (start) begin
            m_busy = 1;
            repeat (rdy_dly) tick();
            chk("acc_valid_in_req", 32'(bus_if.io_acc_valid), 32'd1);
            bus_if.io_acc_ready = 1; tick(); bus_if.io_acc_ready = 0;
            repeat (resp_dly) tick();
            resp_pulse(err, rdata);
            m_busy = 0;
            if (resp_dly <= TIMEOUT - 1) begin
                if (err) m_cmderr = 3'd3;
                else if (!c[16]) m_data0 = rdata;
            end else m_cmderr = 3'd3;
        end
    endtask

    // Read-data monitor: a read seen at a negedge is checked at the next negedge.
    logic rd_pend = 1'b0;
    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rd_unexpected: got 0x%08h expected no read", bus_if.io_rd_data);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk("rd_data", bus_if.io_rd_data, e.data);
                $display("RD  addr=0x%02h data=0x%08h exp=0x%08h", e.addr, bus_if.io_rd_data, e.data);
            end
        end
        rd_pend <= bus_if.io_reg_en & ~bus_if.io_reg_wr_en & rst_n;
    end

    // Access-request monitor: compared at every valid&ready handshake.
    always @(negedge clk) begin
        if (bus_if.io_acc_valid && bus_if.io_acc_ready) begin
            if (acc_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL acc_unexpected: got regno=0x%04h expected no request", bus_if.io_acc_regno);
            end else begin
                acc_t e;
                e = acc_q.pop_front();
                chk("acc_write", 32'(bus_if.io_acc_write), 32'(e.w));
                chk("acc_regno", 32'(bus_if.io_acc_regno), 32'(e.regno));
                chk("acc_wdata", bus_if.io_acc_wdata, e.wdata);
                $display("ACC write=%0d regno=0x%04h wdata=0x%08h", bus_if.io_acc_write,
                         bus_if.io_acc_regno, bus_if.io_acc_wdata);
            end
        end
        if (resumereq) resume_cnt++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] c;
        logic [6:0]  a;
        rst_n = 0; hard_rst = 0; halted = 0;
        bus_if.io_reg_en = 0; bus_if.io_reg_wr_en = 0; bus_if.io_reg_wr_addr = 0; bus_if.io_reg_wr_data = 0;
        bus_if.io_acc_ready = 0; bus_if.io_acc_resp_valid = 0; bus_if.io_acc_resp_err = 0;
        bus_if.io_acc_resp_data = 0;
        model_clear();
        tick(); tick();
        chk("rst_rd_data",   bus_if.io_rd_data, 32'd0);
        chk("rst_acc_valid", 32'(bus_if.io_acc_valid), 32'd0);
        chk("rst_outputs",   {29'd0, haltreq, resumereq, ndmreset}, 32'd0);
        rst_n = 1;
        dmi_read(7'h11);
        dmi_read(7'h16);

        // GPR read
        dmi_write(7'h10, 32'h1);
        halted = 1;
        run_cmd(32'h0022_1001, 2, 3, 0, 32'hDEAD_BEEF);
        dmi_read(7'h04);
        dmi_read(7'h16);

        // GPR write
        dmi_write(7'h04, 32'h1234);
        run_cmd(32'h0023_1005, 0, 1, 0, 32'h0);
        dmi_read(7'h04);

        // Errors and cmderr W1C
        halted = 0;
        run_cmd(32'h0022_1001, 0, 0, 0, 32'h0);
        dmi_read(7'h16);
        dmi_write(7'h16, 32'h700);
        dmi_read(7'h16);
        halted = 1;
        run_cmd(32'h0122_1001, 0, 0, 0, 32'h0);
        run_cmd(32'h0022_1001, 0, 0, 0, 32'h0);   // ignored while cmderr set
        dmi_read(7'h16);
        dmi_write(7'h16, 32'h700);

        // Response on the last allowed cycle, then one cycle too late
        run_cmd(32'h0022_1002, 0, TIMEOUT - 1, 0, 32'hA5A5_0001);
        dmi_read(7'h04);
        run_cmd(32'h0022_1002, 0, TIMEOUT, 0, 32'h5A5A_0002);
        dmi_read(7'h16);
        dmi_read(7'h04);
        dmi_write(7'h16, 32'h700);

        // Busy accesses, then timeout with a late response
        run_cmd(32'h0022_1003, 1, 0, 1, 32'h0);   // error response
        dmi_read(7'h16);
        dmi_write(7'h16, 32'h700);
        begin
            acc_t e;
            bit   st;
            model_cmd(32'h0022_1004, st);
            e.w = 0; e.regno = 16'h1004; e.wdata = m_data0;
            if (st) acc_q.push_back(e);
            bus_access(1'b1, 7'h17, 32'h0022_1004);
            m_busy = st;
            bus_if.io_acc_ready = 1; tick(); bus_if.io_acc_ready = 0;
            dmi_write(7'h04, 32'hCAFE_0000);
            dmi_write(7'h16, 32'h700);
            dmi_read(7'h16);
            dmi_read(7'h04);
            repeat (TIMEOUT + 4) tick();
            m_busy = 0; m_cmderr = 3'd3;
            dmi_read(7'h16);
            resp_pulse(0, 32'h7777_7777);
            dmi_read(7'h04);
            dmi_write(7'h16, 32'h700);
        end

        // Abort in REQ (ready held afterwards must not handshake) and in WAIT
        dmi_write(7'h04, 32'h0BAD_F00D);
        bus_access(1'b1, 7'h17, 32'h0022_1005);
        chk("abort_req_valid", 32'(bus_if.io_acc_valid), 32'd1);
        dmi_write(7'h10, 32'h0);
        chk("abort_acc_valid", 32'(bus_if.io_acc_valid), 32'd0);
        bus_if.io_acc_ready = 1; tick(); tick(); bus_if.io_acc_ready = 0;
        dmi_read(7'h16);
        dmi_read(7'h10);
        dmi_read(7'h04);
        dmi_write(7'h10, 32'h1);
        dmi_write(7'h04, 32'h0000_BEEF);
        begin
            acc_t e;
            e.w = 0; e.regno = 16'h1006; e.wdata = 32'h0000_BEEF;
            acc_q.push_back(e);
            bus_access(1'b1, 7'h17, 32'h0022_1006);
            bus_if.io_acc_ready = 1; tick(); bus_if.io_acc_ready = 0;
            dmi_write(7'h10, 32'h0);
            resp_pulse(0, 32'h1111_2222);
            dmi_read(7'h04);
            dmi_read(7'h16);
        end

        // resumereq pulse, haltreq/ndmreset, hard reset
        dmi_write(7'h10, 32'h4000_0001);
        dmi_write(7'h10, 32'hC000_0003);
        tick();
        chk("resume_pulses", 32'(resume_cnt), 32'(m_resume_exp));
        chk("haltreq_on",  32'(haltreq),  32'd1);
        chk("ndmreset_on", 32'(ndmreset), 32'd1);
        dmi_write(7'h04, 32'h55);
        hard_rst = 1; tick(); hard_rst = 0;
        model_clear();
        chk("hard_haltreq", 32'(haltreq), 32'd0);
        dmi_read(7'h10);
        dmi_read(7'h04);

        // Randomised traffic
        dmi_write(7'h10, 32'h1);
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 5) == 0) halted = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 9))
                0, 1: dmi_write(7'h04, $urandom);
                2: begin
                    d = $urandom;
                    d[0] = ($urandom_range(0, 7) != 0);
                    dmi_write(7'h10, d);
                end
                3: dmi_write(7'h16, $urandom);
                4, 5: begin
                    c = $urandom;
                    if ($urandom_range(0, 7) != 0) c[31:24] = 8'd0;
                    if ($urandom_range(0, 7) != 0) c[22:20] = 3'd2;
                    c[17] = ($urandom_range(0, 3) != 0);
                    run_cmd(c, $urandom_range(0, 3), $urandom_range(0, 6),
                            ($urandom_range(0, 4) == 0), $urandom);
                end
                default: begin
                    case ($urandom_range(0, 5))
                        0: a = 7'h04;
                        1: a = 7'h10;
                        2: a = 7'h11;
                        3: a = 7'h16;
                        4: a = 7'h17;
                        default: a = 7'($urandom_range(0, 127));
                    endcase
                    dmi_read(a);
                end
            endcase
            chk("rand_haltreq",  32'(haltreq),  32'(m_haltreq & m_dmactive));
            chk("rand_ndmreset", 32'(ndmreset), 32'(m_ndmreset & m_dmactive));
        end

        repeat (3) tick();
        chk("rd_queue_drained",  32'(rd_q.size()),  32'd0);
        chk("acc_queue_drained", 32'(acc_q.size()), 32'd0);
        chk("resume_total",      32'(resume_cnt),   32'(m_resume_exp));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
